// File: rtl/softmax_max_finder_pkg.sv
// -----------------------------------------------------------------------------
// softmax_max_finder_pkg
// Constants shared between the softmax max finder and the softmax stage that
// consumes its results, plus the scan FSM state encoding.
//   N        : rows processed in parallel
//   CHAR_NUM : logits per row
//   N_LEN    : logit width (signed two's-complement fixed point)
//   CHAR_LEN : index width, clog2(CHAR_NUM)
// -----------------------------------------------------------------------------
package softmax_max_finder_pkg;

    localparam int N        = 4;
    localparam int CHAR_NUM = 200;
    localparam int N_LEN    = 16;
    localparam int CHAR_LEN = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/softmax_max_finder_max_tree_row.sv
// -----------------------------------------------------------------------------
// max_tree_row
// Per-row signed max/argmax over one LANES-wide chunk, folded into a running
// max/idx register pair.
// Ports:
//   clk, rst  : clock, synchronous active-high reset
//   init      : load running max with the most negative value, idx with 0
//   upd       : fold the current chunk into the running max/idx
//   chunk     : LANES signed elements, lane l at [l*N_LEN +: N_LEN]
//   base_idx  : row index of lane 0 of this chunk
//   nxt_max   : running max after folding the current chunk (combinational)
//   nxt_idx   : index belonging to nxt_max (combinational)
// -----------------------------------------------------------------------------
module max_tree_row
    import softmax_max_finder_pkg::*;
#(
    parameter int LANES = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     init,
    input  logic                     upd,
    input  logic [LANES*N_LEN-1:0]   chunk,
    input  logic [CHAR_LEN-1:0]      base_idx,
    output logic [N_LEN-1:0]         nxt_max,
    output logic [CHAR_LEN-1:0]      nxt_idx
);

    logic signed [N_LEN-1:0]    run_max_p0;
    logic        [CHAR_LEN-1:0] run_idx_p0;
    logic signed [N_LEN-1:0]    lane_max;
    logic        [CHAR_LEN-1:0] lane_sel;

    // Strict greater-than while walking upward keeps the lowest lane on ties.
    always_comb begin
        lane_max = chunk[N_LEN-1:0];
        lane_sel = '0;
        for (int l = 1; l < LANES; l++) begin
            if ($signed(chunk[l*N_LEN +: N_LEN]) > lane_max) begin
                lane_max = chunk[l*N_LEN +: N_LEN];
                lane_sel = CHAR_LEN'(l);
            end
        end
    end

    // Earlier chunks win ties, so the running value is replaced only on
    // strictly greater.
    always_comb begin
        nxt_max = run_max_p0;
        nxt_idx = run_idx_p0;
        if (lane_max > run_max_p0) begin
            nxt_max = lane_max;
            nxt_idx = base_idx + lane_sel;
        end
    end

    // ---- running max/idx register stage ----
    always_ff @(posedge clk) begin
        if (rst) begin
            run_max_p0 <= '0;
            run_idx_p0 <= '0;
        end else if (init) begin
            run_max_p0 <= {1'b1, {(N_LEN-1){1'b0}}};
            run_idx_p0 <= '0;
        end else if (upd) begin
            run_max_p0 <= nxt_max;
            run_idx_p0 <= nxt_idx;
        end
    end

endmodule

// File: rtl/softmax_max_finder.sv
// -----------------------------------------------------------------------------
// softmax_max_finder
// Captures N rows of CHAR_NUM signed logits on run and scans every row
// LANES elements per cycle, producing each row's maximum and its index.
// Ports:
//   clk       : clock, rising edge
//   rst       : synchronous active-high reset, highest priority
//   run       : start pulse, samples d on the same edge (ignored while busy)
//   d         : logits, row i at [i*CHAR_NUM*N_LEN +: CHAR_NUM*N_LEN],
//               element j at [j*N_LEN +: N_LEN] within the row
//   busy      : high while scanning
//   valid     : results valid, held until the next accepted run or rst
//   d_max     : row maxima, row i at [i*N_LEN +: N_LEN]
//   d_max_idx : index of each maximum, row i at [i*CHAR_LEN +: CHAR_LEN]
// -----------------------------------------------------------------------------
module softmax_max_finder
    import softmax_max_finder_pkg::*;
#(
    parameter int LANES = 8
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          run,
    input  logic [N*CHAR_NUM*N_LEN-1:0]   d,
    output logic                          busy,
    output logic                          valid,
    output logic [N*N_LEN-1:0]            d_max,
    output logic [N*CHAR_LEN-1:0]         d_max_idx
);

    localparam int K       = CHAR_NUM / LANES;
    localparam int CNT_W   = (K > 1) ? $clog2(K) : 1;
    localparam int ROW_W   = CHAR_NUM * N_LEN;
    localparam int CHUNK_W = LANES * N_LEN;

    state_t                  state_q;
    state_t                  state_nxt;
    logic [CNT_W-1:0]        cnt_q;
    logic [N*ROW_W-1:0]      buf_q;
    logic                    start;
    logic                    step;
    logic                    last;
    logic [CHAR_LEN-1:0]     base_idx;
    logic [N*N_LEN-1:0]      row_max_nxt;
    logic [N*CHAR_LEN-1:0]   row_idx_nxt;

    always_comb begin
        state_nxt = state_q;
        start     = 1'b0;
        step      = 1'b0;
        last      = 1'b0;
        case (state_q)
            IDLE, DONE: begin
                if (run) begin
                    start     = 1'b1;
                    state_nxt = SCAN;
                end
            end
            SCAN: begin
                step = 1'b1;
                if (cnt_q == CNT_W'(K-1)) begin
                    last      = 1'b1;
                    state_nxt = DONE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign base_idx = CHAR_LEN'(32'(cnt_q) * LANES);

    for (genvar i = 0; i < N; i++) begin : g_row
        logic [CHUNK_W-1:0] chunk;

        assign chunk = buf_q[i*ROW_W + 32'(cnt_q)*CHUNK_W +: CHUNK_W];

        max_tree_row #(
            .LANES (LANES)
        ) u_row (
            .clk      (clk),
            .rst      (rst),
            .init     (start),
            .upd      (step),
            .chunk    (chunk),
            .base_idx (base_idx),
            .nxt_max  (row_max_nxt[i*N_LEN +: N_LEN]),
            .nxt_idx  (row_idx_nxt[i*CHAR_LEN +: CHAR_LEN])
        );
    end

    // ---- control / capture / result register stage ----
    // The final chunk is folded and published on the same edge, so the
    // outputs take the combinational next value rather than the registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            busy      <= 1'b0;
            valid     <= 1'b0;
            d_max     <= '0;
            d_max_idx <= '0;
            buf_q     <= '0;
        end else begin
            state_q <= state_nxt;
            if (start) begin
                buf_q <= d;
                cnt_q <= '0;
                busy  <= 1'b1;
                valid <= 1'b0;
            end else if (step) begin
                cnt_q <= cnt_q + CNT_W'(1);
                if (last) begin
                    busy      <= 1'b0;
                    valid     <= 1'b1;
                    d_max     <= row_max_nxt;
                    d_max_idx <= row_idx_nxt;
                end
            end
        end
    end

endmodule

// File: tb/tb_softmax_max_finder.sv
// -----------------------------------------------------------------------------
// tb_softmax_max_finder
// Directed bench for softmax_max_finder: reset, hand-computed rows, signed and
// tie-break cases, ignored run during a scan, back-to-back runs, mid-scan
// reset, and randomized rows against a lowest-index argmax reference.
// -----------------------------------------------------------------------------
module tb_softmax_max_finder;
    import softmax_max_finder_pkg::*;

    localparam int TOT   = N * CHAR_NUM * N_LEN;
    localparam int ROW_W = CHAR_NUM * N_LEN;

    logic                     clk = 1'b0;
    logic                     rst;
    logic                     run;
    logic [TOT-1:0]           d;
    logic                     busy;
    logic                     valid;
    logic [N*N_LEN-1:0]       d_max;
    logic [N*CHAR_LEN-1:0]    d_max_idx;

    int          n_vec = 0;
    int          n_err = 0;
    int          edges;
    int          bcnt;
    logic [63:0] em;
    logic [63:0] ei;

    always #5 clk = ~clk;

    softmax_max_finder dut (
        .clk       (clk),
        .rst       (rst),
        .run       (run),
        .d         (d),
        .busy      (busy),
        .valid     (valid),
        .d_max     (d_max),
        .d_max_idx (d_max_idx)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic set_el(input int r, input int j, input logic [15:0] v);
        d[r*ROW_W + j*N_LEN +: N_LEN] = v;
    endtask

    task automatic fill_row(input int r, input logic [15:0] v);
        for (int j = 0; j < CHAR_NUM; j++) set_el(r, j, v);
    endtask

    task automatic scramble();
        for (int w = 0; w < TOT/32; w++) d[w*32 +: 32] = $urandom();
    endtask

    // Reference: plain walk over the whole row, first occurrence of the max.
    task automatic ref_model(input logic [TOT-1:0] v, output logic [63:0] m, output logic [63:0] ix);
        logic signed [N_LEN-1:0] best;
        logic signed [N_LEN-1:0] e;
        int bi;
        m  = '0;
        ix = '0;
        for (int r = 0; r < N; r++) begin
            best = v[r*ROW_W +: N_LEN];
            bi   = 0;
            for (int j = 1; j < CHAR_NUM; j++) begin
                e = v[r*ROW_W + j*N_LEN +: N_LEN];
                if (e > best) begin
                    best = e;
                    bi   = j;
                end
            end
            m[r*N_LEN +: N_LEN]        = best;
            ix[r*CHAR_LEN +: CHAR_LEN] = 8'(bi);
        end
    endtask

    // Called just after a negedge. Pulses run, garbles d after the run edge,
    // optionally re-pulses run at a given edge count, and waits (bounded) for
    // valid. edges counts posedges including the run edge.
    task automatic do_scan(input int rerun_at, output int e_cnt, output int b_cnt);
        run = 1'b1;
        @(negedge clk);
        run   = 1'b0;
        e_cnt = 1;
        b_cnt = 0;
        scramble();
        check("busy_after_run", busy, 1);
        check("valid_drop_on_run", valid, 0);
        while (valid !== 1'b1 && e_cnt < 40) begin
            if (busy === 1'b1) b_cnt++;
            run = (e_cnt == rerun_at);
            if (e_cnt == rerun_at) scramble();
            @(negedge clk);
            e_cnt++;
        end
        run = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        run = 1'b0;
        d   = '0;
        repeat (3) @(negedge clk);
        check("rst_valid", valid, 0);
        check("rst_busy", busy, 0);
        check("rst_dmax", d_max, 0);
        check("rst_idx", d_max_idx, 0);
        rst = 1'b0;
        @(negedge clk);
        check("idle_valid", valid, 0);

        // Basic rows, with an ignored run pulse at scan cycle 12.
        d = '0;
        set_el(0, 137, 16'h0120);
        set_el(1, 0, 16'h7FFF);
        fill_row(2, 16'hFFFF);
        set_el(2, 199, 16'h0005);
        for (int j = 0; j < CHAR_NUM; j++) set_el(3, j, 16'(j));
        do_scan(12, edges, bcnt);
        check("basic_latency", 64'(edges), 26);
        check("basic_busy_cycles", 64'(bcnt), 25);
        check("basic_max", d_max, 64'h00C7_0005_7FFF_0120);
        check("basic_idx", d_max_idx, 32'hC7C7_0089);
        check("basic_busy_done", busy, 0);

        // Back-to-back: run in the first DONE cycle; signed and tie cases.
        d = '0;
        fill_row(0, 16'h8000);
        set_el(1, 3, 16'h0040);
        set_el(1, 50, 16'h0040);
        set_el(1, 199, 16'h0040);
        set_el(2, 61, 16'h0040);
        set_el(2, 58, 16'h0040);
        fill_row(3, 16'h8000);
        set_el(3, 100, 16'h8001);
        do_scan(0, edges, bcnt);
        check("b2b_latency", 64'(edges), 26);
        check("b2b_busy_cycles", 64'(bcnt), 25);
        check("tie_max", d_max, 64'h8001_0040_0040_8000);
        check("tie_idx", d_max_idx, 32'h643A_0300);
        repeat (5) @(negedge clk);
        check("hold_valid", valid, 1);
        check("hold_max", d_max, 64'h8001_0040_0040_8000);
        check("hold_idx", d_max_idx, 32'h643A_0300);

        // Reset in the middle of a scan.
        scramble();
        run = 1'b1;
        @(negedge clk);
        run = 1'b0;
        repeat (9) @(negedge clk);
        check("midscan_busy", busy, 1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("abort_busy", busy, 0);
        check("abort_valid", valid, 0);
        check("abort_max", d_max, 0);
        check("abort_idx", d_max_idx, 0);
        repeat (3) @(negedge clk);
        check("abort_stays_idle", busy, 0);

        // Randomized rows: full range, tiny range (many ties), near minimum.
        for (int s = 0; s < 125; s++) begin
            for (int r = 0; r < N; r++) begin
                int mode;
                mode = $urandom_range(0, 2);
                for (int j = 0; j < CHAR_NUM; j++) begin
                    if (mode == 0)      set_el(r, j, 16'($urandom()));
                    else if (mode == 1) set_el(r, j, 16'($urandom_range(0, 4)) - 16'd2);
                    else                set_el(r, j, 16'h8000 | 16'($urandom_range(0, 3)));
                end
            end
            ref_model(d, em, ei);
            do_scan(0, edges, bcnt);
            check("rand_latency", 64'(edges), 26);
            check("rand_max", d_max, em);
            check("rand_idx", d_max_idx, ei);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
